// File: rtl/exp4_condicionador_entradas.sv
// Input conditioner for the memory game: 2-FF synchronisers, debounced one-hot play/error strobes and start pulse.
// Optional macro CONDICIONADOR_DB_EN adds the db_estado debug output (switch FSM state code).
module exp4_condicionador_entradas #(
   parameter int CICLOS_DEBOUNCE = 50000,
   parameter int CONT_W          = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] chaves,
   input  logic       iniciar,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       erro_multipla,
   output logic       iniciar_limpo,
   output logic       iniciar_pulso
`ifdef CONDICIONADOR_DB_EN
   ,
   output logic [3:0] db_estado
`endif
);

   typedef enum logic [1:0] {
      OCIOSO      = 2'd0,
      FILTRANDO   = 2'd1,
      PRESSIONADO = 2'd2,
      SOLTANDO    = 2'd3
   } estado_t;

   localparam logic [CONT_W-1:0] LIMITE = CONT_W'(CICLOS_DEBOUNCE - 1);
   localparam logic [CONT_W-1:0] UM     = {{(CONT_W-1){1'b0}}, 1'b1};
   localparam logic [CONT_W-1:0] ZERO   = '0;

   function automatic logic um_quente(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   logic [4:0]        sinc1_q, sinc2_q;
   logic [3:0]        amostra;
   logic              amostra_ini;

   estado_t           estado_q, estado_d;
   logic [3:0]        ref_q, ref_d;
   logic [CONT_W-1:0] cont_q, cont_d;
   logic [3:0]        jogada_q, jogada_d;
   logic              feita_q, feita_d;
   logic              erro_q, erro_d;

   logic [CONT_W-1:0] cont_ini_q, cont_ini_d;
   logic              limpo_q, limpo_d;
   logic              pulso_q, pulso_d;

   assign amostra     = sinc2_q[3:0];
   assign amostra_ini = sinc2_q[4];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc1_q    <= '0;
         sinc2_q    <= '0;
         estado_q   <= OCIOSO;
         ref_q      <= '0;
         cont_q     <= '0;
         jogada_q   <= '0;
         feita_q    <= 1'b0;
         erro_q     <= 1'b0;
         cont_ini_q <= '0;
         limpo_q    <= 1'b0;
         pulso_q    <= 1'b0;
      end else begin
         sinc1_q    <= {iniciar, chaves};
         sinc2_q    <= sinc1_q;
         estado_q   <= estado_d;
         ref_q      <= ref_d;
         cont_q     <= cont_d;
         jogada_q   <= jogada_d;
         feita_q    <= feita_d;
         erro_q     <= erro_d;
         cont_ini_q <= cont_ini_d;
         limpo_q    <= limpo_d;
         pulso_q    <= pulso_d;
      end
   end

   // Switch FSM: a code must be seen CICLOS_DEBOUNCE times in a row before it is judged
   always_comb begin
      estado_d = estado_q;
      ref_d    = ref_q;
      cont_d   = cont_q;
      jogada_d = jogada_q;
      feita_d  = 1'b0;
      erro_d   = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (amostra != 4'b0000) begin
               estado_d = FILTRANDO;
               ref_d    = amostra;
               cont_d   = UM;
            end
         end
         FILTRANDO: begin
            if (amostra == 4'b0000) begin
               estado_d = OCIOSO;
            end else if (amostra != ref_q) begin
               ref_d  = amostra;
               cont_d = UM;
            end else if (cont_q == LIMITE) begin
               estado_d = PRESSIONADO;
               if (um_quente(ref_q)) begin
                  jogada_d = ref_q;
                  feita_d  = 1'b1;
               end else begin
                  erro_d = 1'b1;
               end
            end else begin
               cont_d = cont_q + UM;
            end
         end
         PRESSIONADO: begin
            if (amostra == 4'b0000) begin
               estado_d = SOLTANDO;
               cont_d   = UM;
            end
         end
         SOLTANDO: begin
            if (amostra != 4'b0000) begin
               estado_d = PRESSIONADO;
            end else if (cont_q == LIMITE) begin
               estado_d = OCIOSO;
            end else begin
               cont_d = cont_q + UM;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // Start button: level flips only after a full run of samples disagreeing with it
   always_comb begin
      cont_ini_d = cont_ini_q;
      limpo_d    = limpo_q;
      pulso_d    = 1'b0;
      if (amostra_ini == limpo_q) begin
         cont_ini_d = ZERO;
      end else if (cont_ini_q == LIMITE) begin
         cont_ini_d = ZERO;
         limpo_d    = ~limpo_q;
         pulso_d    = ~limpo_q;
      end else begin
         cont_ini_d = cont_ini_q + UM;
      end
   end

   assign jogada        = jogada_q;
   assign jogada_feita  = feita_q;
   assign erro_multipla = erro_q;
   assign iniciar_limpo = limpo_q;
   assign iniciar_pulso = pulso_q;
`ifdef CONDICIONADOR_DB_EN
   assign db_estado     = {2'b00, estado_q};
`endif

endmodule

// File: tb/tb_exp4_condicionador_entradas.sv
// Bench for exp4_condicionador_entradas: directed scenarios plus random stimulus against a run-length reference model.
module tb_exp4_condicionador_entradas;

   localparam int CD = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] chaves = 4'b0000;
   logic       iniciar = 1'b0;
   logic [3:0] jogada;
   logic       jogada_feita, erro_multipla, iniciar_limpo, iniciar_pulso;
`ifdef CONDICIONADOR_DB_EN
   logic [3:0] db_estado;
`endif

   exp4_condicionador_entradas #(.CICLOS_DEBOUNCE(CD), .CONT_W(16)) dut (
      .clock(clock),
      .reset(reset),
      .chaves(chaves),
      .iniciar(iniciar),
      .jogada(jogada),
      .jogada_feita(jogada_feita),
      .erro_multipla(erro_multipla),
      .iniciar_limpo(iniciar_limpo),
      .iniciar_pulso(iniciar_pulso)
`ifdef CONDICIONADOR_DB_EN
      ,
      .db_estado(db_estado)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_erros  = 0;
   int cnt_feita = 0, cnt_erro = 0, cnt_pulso = 0;

   task automatic chk(input string tag, input int obs, input int esp);
      n_checks++;
      if (obs != esp) begin
         n_erros++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
      end
   endtask

   // Reference model: pin history delayed by two edges, then run-length rules
   logic [3:0] m_lin0, m_lin1;
   logic       m_ini0, m_ini1;
   bit         m_trav;
   int         m_run, m_zrun, m_drun;
   logic [3:0] m_ult, m_jog;
   bit         m_feita, m_erro, m_limpo, m_pulso;

   task automatic modelo_reset();
      m_lin0 = '0; m_lin1 = '0; m_ini0 = 0; m_ini1 = 0;
      m_trav = 0; m_run = 0; m_zrun = 0; m_drun = 0;
      m_ult = '0; m_jog = '0;
      m_feita = 0; m_erro = 0; m_limpo = 0; m_pulso = 0;
   endtask

   task automatic modelo_borda();
      logic [3:0] a;
      logic       ai;
      a = m_lin1;
      ai = m_ini1;
      m_feita = 0; m_erro = 0; m_pulso = 0;
      if (!m_trav) begin
         if (a == 4'b0000) m_run = 0;
         else begin
            if (m_run > 0 && a == m_ult) m_run++;
            else m_run = 1;
            m_ult = a;
            if (m_run == CD) begin
               m_trav = 1; m_zrun = 0; m_run = 0;
               if ($countones(a) == 1) begin m_jog = a; m_feita = 1; end
               else m_erro = 1;
            end
         end
      end else begin
         if (a == 4'b0000) begin
            m_zrun++;
            if (m_zrun == CD) begin m_trav = 0; m_run = 0; end
         end else m_zrun = 0;
      end
      if (ai != m_limpo) begin
         m_drun++;
         if (m_drun == CD) begin
            m_limpo = ~m_limpo; m_drun = 0; m_pulso = m_limpo;
         end
      end else m_drun = 0;
      m_lin1 = m_lin0; m_lin0 = chaves;
      m_ini1 = m_ini0; m_ini0 = iniciar;
   endtask

   task automatic compara();
      chk("jogada", int'(jogada), int'(m_jog));
      chk("jogada_feita", int'(jogada_feita), int'(m_feita));
      chk("erro_multipla", int'(erro_multipla), int'(m_erro));
      chk("iniciar_limpo", int'(iniciar_limpo), int'(m_limpo));
      chk("iniciar_pulso", int'(iniciar_pulso), int'(m_pulso));
   endtask

   task automatic ciclo();
      @(posedge clock);
      if (reset) modelo_borda();
      #1;
      compara();
      cnt_feita += int'(jogada_feita);
      cnt_erro  += int'(erro_multipla);
      cnt_pulso += int'(iniciar_pulso);
   endtask

   task automatic ciclos(input int n);
      for (int i = 0; i < n; i++) ciclo();
   endtask

   task automatic pulso_reset();
      reset = 1'b0;
      #1;
      modelo_reset();
      compara();
`ifdef CONDICIONADOR_DB_EN
      chk("db_estado_reset", int'(db_estado), 0);
`endif
      reset = 1'b1;
   endtask

   initial begin
      int hc, hi;
      modelo_reset();

      // Reset held with a code on the pins
      chaves = 4'b0100;
      ciclos(3);
`ifdef CONDICIONADOR_DB_EN
      chk("db_estado_em_reset", int'(db_estado), 0);
`endif
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         ciclo();
         chk("latencia_feita", int'(jogada_feita), int'(k == 6));
      end
      chk("jogada_0100", int'(jogada), 4);
      chaves = 4'b0000; ciclos(6);

      // Bouncing input, then stable
      cnt_feita = 0;
      for (int i = 0; i < 20; i++) begin
         chaves = (((i / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
         ciclo();
      end
      chk("bounce_sem_strobe", cnt_feita, 0);
      chaves = 4'b0100; ciclos(8);
      chk("bounce_um_strobe", cnt_feita, 1);
      chk("bounce_jogada", int'(jogada), 4);
      chaves = 4'b0000; ciclos(6);

      // Multi-key code
      cnt_feita = 0; cnt_erro = 0;
      chaves = 4'b0110; ciclos(10);
      chk("multi_erro", cnt_erro, 1);
      chk("multi_sem_feita", cnt_feita, 0);
      chk("multi_jogada_mantida", int'(jogada), 4);
      chaves = 4'b0000; ciclos(6);

      // New code while still pressed is ignored
      chaves = 4'b0001; ciclos(8);
      chk("aceita_0001", int'(jogada), 1);
      cnt_feita = 0;
      chaves = 4'b1000; ciclos(8);
      chk("troca_sem_soltar", cnt_feita, 0);
      chk("jogada_ainda_0001", int'(jogada), 1);
      chaves = 4'b0000; ciclos(10);
      chaves = 4'b1000; ciclos(8);
      chk("nova_pressao", cnt_feita, 1);
      chk("jogada_1000", int'(jogada), 8);
      chaves = 4'b0000; ciclos(6);

      // Start button
      cnt_pulso = 0;
      iniciar = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         ciclo();
         chk("ini_subida", int'(iniciar_limpo), int'(k >= 6));
      end
      chk("ini_um_pulso", cnt_pulso, 1);
      iniciar = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         ciclo();
         chk("ini_descida", int'(iniciar_limpo), int'(k < 6));
      end
      chk("ini_sem_pulso_descida", cnt_pulso, 1);

      // Reset in the middle of filtering
      cnt_feita = 0;
      chaves = 4'b0010; ciclos(4);
      pulso_reset();
      chk("reset_meio_jogada", int'(jogada), 0);
      chaves = 4'b0000; ciclos(8);
      chk("reset_meio_sem_strobe", cnt_feita, 0);

      // Random stimulus
      hc = 0; hi = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hc == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: chaves = 4'b0000;
               5, 6, 7:       chaves = 4'b0001 << $urandom_range(0, 3);
               default:       chaves = 4'($urandom_range(0, 15));
            endcase
            hc = $urandom_range(1, 8);
         end
         if (hi == 0) begin
            iniciar = ~iniciar;
            hi = $urandom_range(1, 10);
         end
         hc--; hi--;
         ciclo();
         if ($urandom_range(0, 299) == 0) pulso_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
      $finish;
   end

endmodule
